tdm_demux4: RTL and testbench
=============================

Name: tdm_demux4

Overview:
- Four-lane time-division demultiplexer. It receives a word stream where each frame is four consecutive valid words (lane a, b, c, d), marked by a frame-sync flag on the first word.
- It registers each complete frame onto four parallel output lanes and updates all four lanes atomically.
- It is the receive end of a 4-to-1 select-driven multiplexed link. Upstream, a 2-bit slot select steps through lanes a..d.

Parameters:
- DATA_W, 4, width of each data word and each output lane.
- CNT_W, 8, width of the completed-frame counter.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- data_in  input  DATA_W  incoming word.
- valid  input  1  data_in is valid this cycle.
- sync  input  1  marks data_in as the slot-0 (lane a) word of a frame; ignored unless valid=1.
- out_a, out_b, out_c, out_d  output  DATA_W each  lane registers of the last complete frame.
- frame_done  output  1  one-cycle pulse when the lane registers are updated.
- sync_err  output  1  one-cycle pulse when sync arrives mid-frame.
- slot  output  2  index of the next expected slot (0..3).
- frame_cnt  output  CNT_W  count of completed frames.

Behaviour:
- Interface: one clock, clk; reset_n is asynchronous and active-low.
- Reset (reset_n=0, asynchronous):
  - out_a..out_d=0, frame_done=0, sync_err=0, slot=0, frame_cnt=0.
  - Shadow registers are cleared to 0 and the FSM returns to IDLE.
  - Reset asserted mid-frame discards the partial frame; the outputs do not keep the previous frame.
- All outputs are registered. The FSM has two states, IDLE and RECV, plus shadow registers sh0..sh2.
- IDLE (slot=0):
  - valid=1, sync=1: sh0<=data_in, slot<=1, go to RECV.
  - valid=1, sync=0: word dropped; no state change, no error.
  - valid=0: hold.
- RECV (slot=1..3):
  - valid=0: hold all state. Gaps of any length between words are legal.
  - valid=1, sync=0, slot=1 or 2: sh[slot]<=data_in, slot<=slot+1.
  - valid=1, sync=0, slot=3, all at the same edge:
    - out_a<=sh0, out_b<=sh1, out_c<=sh2, out_d<=data_in.
    - frame_done<=1, frame_cnt<=frame_cnt+1.
    - slot<=0, go to IDLE.
  - valid=1, sync=1 (any slot 1..3), at the same edge:
    - sync_err<=1.
    - The partial frame is abandoned and this word starts a new frame: sh0<=data_in, slot<=1, stay in RECV.
    - out_* and frame_cnt are unchanged.
- Latency: the lane outputs and frame_done become visible in the cycle after the clock edge that sampled the slot-3 word.
- frame_done and sync_err are high for exactly one cycle per event and never assert together.
- Back-to-back frames: a sync word in the cycle immediately after a slot-3 word is accepted normally. The FSM is in IDLE, so no error is flagged.
- frame_cnt wraps modulo 2^CNT_W (255 -> 0 at the default); no saturation.
- out_* change only on frame completion or reset. A partial frame never appears on the outputs.
- sync with valid=0 has no effect in any state.

Test Plan:
- Reset, then a frame of 4 consecutive valid words (1,2,3,4; sync on 1) -> one cycle after the 4th edge: out_a..d=1,2,3,4, frame_done=1 for one cycle, frame_cnt=1, slot=0.
- Same frame with valid=0 gaps of 0, 3 and 1 cycles between words -> identical result; slot holds during gaps; out_* stay 0 until completion.
- Words 5,6 (sync on 5), then sync with word 9, then 10,11,12 -> sync_err pulses once on the word-9 edge; frame completes as 9,10,11,12; frame_cnt increments by one only.
- 300 back-to-back frames with no idle cycles -> frame_done every 4th cycle, no sync_err, frame_cnt=44 (300 mod 256) at the end.
- In IDLE, 3 valid words without sync, then a proper frame A,B,C,D -> the leading words are dropped silently; out_*=A,B,C,D.
- Assert reset_n=0 asynchronously between clock edges after slot-2 capture -> all outputs 0 immediately; then a full frame completes normally with frame_cnt=1.

Source files
------------

// File: rtl/tdm_demux4.sv
// -----------------------------------------------------------------------------
// tdm_demux4 -- four-lane time-division demultiplexer (receive end of a
// 4-to-1 slot-select multiplexed link).
//
// A frame is four valid words in lane order a, b, c, d. The first word is
// tagged with sync. Words a..c are held in shadow registers. The whole frame
// is copied onto the four lane outputs at the edge that accepts word d, so
// the lanes always show one complete frame and never a partial one.
//
// Ports:
//   clk                 rising-edge clock
//   reset_n             asynchronous active-low reset
//   data_in[DATA_W]     incoming word
//   valid               data_in is valid this cycle
//   sync                data_in is the lane-a word of a frame (needs valid)
//   out_a..out_d        lanes of the last complete frame
//   frame_done          one-cycle pulse when the lanes are updated
//   sync_err            one-cycle pulse when sync arrives mid-frame
//   slot[2]             index of the next expected slot (0..3)
//   frame_cnt[CNT_W]    completed-frame counter, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module tdm_demux4 #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid,
    input  logic              sync,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [DATA_W-1:0] out_c,
    output logic [DATA_W-1:0] out_d,
    output logic              frame_done,
    output logic              sync_err,
    output logic [1:0]        slot,
    output logic [CNT_W-1:0]  frame_cnt
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } state_t;

    state_t             r_state,     w_state_next;
    logic [1:0]         r_slot,      w_slot_next;
    logic [DATA_W-1:0]  r_sh0,       w_sh0_next;
    logic [DATA_W-1:0]  r_sh1,       w_sh1_next;
    logic [DATA_W-1:0]  r_sh2,       w_sh2_next;
    logic [DATA_W-1:0]  r_out_a,     w_out_a_next;
    logic [DATA_W-1:0]  r_out_b,     w_out_b_next;
    logic [DATA_W-1:0]  r_out_c,     w_out_c_next;
    logic [DATA_W-1:0]  r_out_d,     w_out_d_next;
    logic               r_done,      w_done_next;
    logic               r_err,       w_err_next;
    logic [CNT_W-1:0]   r_cnt,       w_cnt_next;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_slot  <= 2'd0;
            r_sh0   <= '0;
            r_sh1   <= '0;
            r_sh2   <= '0;
            r_out_a <= '0;
            r_out_b <= '0;
            r_out_c <= '0;
            r_out_d <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_slot  <= w_slot_next;
            r_sh0   <= w_sh0_next;
            r_sh1   <= w_sh1_next;
            r_sh2   <= w_sh2_next;
            r_out_a <= w_out_a_next;
            r_out_b <= w_out_b_next;
            r_out_c <= w_out_c_next;
            r_out_d <= w_out_d_next;
            r_done  <= w_done_next;
            r_err   <= w_err_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state and output logic
    always_comb begin
        w_state_next = r_state;
        w_slot_next  = r_slot;
        w_sh0_next   = r_sh0;
        w_sh1_next   = r_sh1;
        w_sh2_next   = r_sh2;
        w_out_a_next = r_out_a;
        w_out_b_next = r_out_b;
        w_out_c_next = r_out_c;
        w_out_d_next = r_out_d;
        w_done_next  = 1'b0;   // pulses: low unless an event fires this edge
        w_err_next   = 1'b0;
        w_cnt_next   = r_cnt;

        case (r_state)
            ST_IDLE: begin
                // Words without sync are dropped silently while idle.
                if (valid && sync) begin
                    w_sh0_next   = data_in;
                    w_slot_next  = 2'd1;
                    w_state_next = ST_RECV;
                end
            end

            ST_RECV: begin
                if (valid) begin
                    if (sync) begin
                        // Resynchronise: the abandoned words are lost and this
                        // word becomes lane a of a fresh frame.
                        w_err_next  = 1'b1;
                        w_sh0_next  = data_in;
                        w_slot_next = 2'd1;
                    end else begin
                        case (r_slot)
                            2'd1: begin
                                w_sh1_next  = data_in;
                                w_slot_next = 2'd2;
                            end
                            2'd2: begin
                                w_sh2_next  = data_in;
                                w_slot_next = 2'd3;
                            end
                            2'd3: begin
                                // Lane d bypasses the shadows so all four lanes
                                // update together at this edge.
                                w_out_a_next = r_sh0;
                                w_out_b_next = r_sh1;
                                w_out_c_next = r_sh2;
                                w_out_d_next = data_in;
                                w_done_next  = 1'b1;
                                w_cnt_next   = r_cnt + CNT_W'(1);
                                w_slot_next  = 2'd0;
                                w_state_next = ST_IDLE;
                            end
                            default: begin
                                // slot 0 never pairs with RECV; recover to IDLE.
                                w_slot_next  = 2'd0;
                                w_state_next = ST_IDLE;
                            end
                        endcase
                    end
                end
            end

            default: begin
                w_slot_next  = 2'd0;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign out_a      = r_out_a;
    assign out_b      = r_out_b;
    assign out_c      = r_out_c;
    assign out_d      = r_out_d;
    assign frame_done = r_done;
    assign sync_err   = r_err;
    assign slot       = r_slot;
    assign frame_cnt  = r_cnt;

endmodule

// File: tb/tb_tdm_demux4.sv
module tb_tdm_demux4;

    localparam int DATA_W = 4;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic              valid = 1'b0;
    logic              sync = 1'b0;
    logic [DATA_W-1:0] out_a, out_b, out_c, out_d;
    logic              frame_done, sync_err;
    logic [1:0]        slot;
    logic [CNT_W-1:0]  frame_cnt;

    tdm_demux4 #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .data_in    (data_in),
        .valid      (valid),
        .sync       (sync),
        .out_a      (out_a),
        .out_b      (out_b),
        .out_c      (out_c),
        .out_d      (out_d),
        .frame_done (frame_done),
        .sync_err   (sync_err),
        .slot       (slot),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: the words of the frame being collected, nothing more.
    int          m_part[$];
    int          m_lane[4];
    bit          m_done, m_err;
    int          m_cnt;
    int          n_done, n_err;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_part.delete();
        for (int i = 0; i < 4; i++) m_lane[i] = 0;
        m_done = 0;
        m_err  = 0;
        m_cnt  = 0;
    endtask

    task automatic model_step(input bit v, input bit s, input int d);
        m_done = 0;
        m_err  = 0;
        if (v) begin
            if (s) begin
                if (m_part.size() > 0) m_err = 1;
                m_part.delete();
                m_part.push_back(d);
            end else if (m_part.size() > 0) begin
                m_part.push_back(d);
                if (m_part.size() == 4) begin
                    for (int i = 0; i < 4; i++) m_lane[i] = m_part[i];
                    m_done = 1;
                    m_cnt  = (m_cnt + 1) % (1 << CNT_W);
                    m_part.delete();
                end
            end
        end
    endtask

    task automatic check_all();
        chk("out_a",      int'(out_a),      m_lane[0]);
        chk("out_b",      int'(out_b),      m_lane[1]);
        chk("out_c",      int'(out_c),      m_lane[2]);
        chk("out_d",      int'(out_d),      m_lane[3]);
        chk("frame_done", int'(frame_done), int'(m_done));
        chk("sync_err",   int'(sync_err),   int'(m_err));
        chk("slot",       int'(slot),       m_part.size());
        chk("frame_cnt",  int'(frame_cnt),  m_cnt);
        if (frame_done) n_done++;
        if (sync_err)   n_err++;
    endtask

    // One clock cycle: drive, let the edge happen, update model, compare.
    task automatic step(input bit v, input bit s, input int d);
        valid   = v;
        sync    = s;
        data_in = DATA_W'(d);
        @(posedge clk);
        model_step(v, s, d);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, $urandom_range(0, 1), $urandom_range(0, 15));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        valid   = 1'b0;
        sync    = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic frame(input int a, input int b, input int c, input int d);
        step(1, 1, a); step(1, 0, b); step(1, 0, c); step(1, 0, d);
    endtask

    initial begin
        model_reset();
        n_done = 0;
        n_err  = 0;
        do_reset();

        // Basic frame
        frame(1, 2, 3, 4);
        $display("frame 1,2,3,4 -> %0d %0d %0d %0d done=%0d cnt=%0d", out_a, out_b, out_c, out_d, frame_done, frame_cnt);
        chk("pin_basic_a", int'(out_a), 1);
        chk("pin_basic_d", int'(out_d), 4);
        chk("pin_basic_done", int'(frame_done), 1);
        chk("pin_basic_cnt", int'(frame_cnt), 1);
        step(0, 0, 0);
        chk("pin_done_one_cycle", int'(frame_done), 0);

        // Same frame with gaps 0,3,1
        do_reset();
        step(1, 1, 1); step(1, 0, 2); idle(3); step(1, 0, 3); idle(1);
        chk("pin_gap_hold_out", int'(out_a), 0);
        chk("pin_gap_hold_slot", int'(slot), 3);
        step(1, 0, 4);
        $display("gapped frame -> %0d %0d %0d %0d cnt=%0d", out_a, out_b, out_c, out_d, frame_cnt);
        chk("pin_gap_c", int'(out_c), 3);
        chk("pin_gap_cnt", int'(frame_cnt), 1);

        // Mid-frame sync
        step(1, 1, 5); step(1, 0, 6); step(1, 1, 9);
        chk("pin_sync_err", int'(sync_err), 1);
        step(1, 0, 10); step(1, 0, 11); step(1, 0, 12);
        $display("resync frame -> %0d %0d %0d %0d cnt=%0d", out_a, out_b, out_c, out_d, frame_cnt);
        chk("pin_resync_a", int'(out_a), 9);
        chk("pin_resync_cnt", int'(frame_cnt), 2);

        // 300 back-to-back frames
        do_reset();
        n_done = 0; n_err = 0;
        for (int f = 0; f < 300; f++)
            frame($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
        $display("300 frames -> cnt=%0d done_pulses=%0d errs=%0d", frame_cnt, n_done, n_err);
        chk("pin_wrap_cnt", int'(frame_cnt), 44);
        chk("pin_b2b_done", n_done, 300);
        chk("pin_b2b_err", n_err, 0);

        // Leading words without sync are dropped
        step(1, 0, 7); step(1, 0, 8); step(1, 0, 9);
        chk("pin_drop_slot", int'(slot), 0);
        frame(10, 11, 12, 13);
        $display("drop then frame -> %0d %0d %0d %0d", out_a, out_b, out_c, out_d);
        chk("pin_drop_a", int'(out_a), 10);
        chk("pin_drop_d", int'(out_d), 13);

        // Asynchronous reset after slot-2 capture
        step(1, 1, 1); step(1, 0, 2); step(1, 0, 3);
        #2;
        reset_n = 1'b0;
        valid   = 1'b0;
        #1;
        model_reset();
        $display("async reset -> out_a=%0d slot=%0d cnt=%0d", out_a, slot, frame_cnt);
        chk("pin_async_out_a", int'(out_a), 0);
        chk("pin_async_slot", int'(slot), 0);
        chk("pin_async_cnt", int'(frame_cnt), 0);
        check_all();
        @(negedge clk);
        reset_n = 1'b1;
        frame(6, 7, 8, 9);
        chk("pin_post_reset_cnt", int'(frame_cnt), 1);
        chk("pin_post_reset_b", int'(out_b), 7);

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bit v;
            bit s;
            v = ($urandom_range(0, 9) < 7);
            s = ($urandom_range(0, 9) < 2);
            step(v, s, $urandom_range(0, 15));
        end
        $display("random traffic -> cnt=%0d slot=%0d", frame_cnt, slot);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
